cop0_regfile: RTL

- Parametrised CP0 register file with architectural state. Successor to the decode-only CP0 handling.
- Holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId.
- Serves MTC0 writes and MFC0 reads from the pipeline.
- Latches exception entry and ERET return from the writeback/commit stage, runs the Count/Compare timer, and raises a masked interrupt request to the exception logic.

---
 rtl/cop0_regs.sv | 41 ++++
 rtl/cop0_timer.sv | 56 +++++
 rtl/cop0_regfile.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cop0_regs.sv
// CP0 register map, Status/Cause field positions, writable masks and ExcCodes.
// Shared by the register file, its timer and anything decoding MFC0/MTC0.
package cop0_regs;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  // BEV is hard-wired to 1; it is the only Status bit set out of reset.
  localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  function automatic logic reg_writable(input logic [4:0] addr);
    return (addr == REG_COUNT) || (addr == REG_COMPARE) || (addr == REG_STATUS) ||
           (addr == REG_CAUSE) || (addr == REG_EPC);
  endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer: prescaled Count, Compare reload and sticky TI flag.
// Single-cycle register updates; no backpressure, MTC0 strobes always accepted.
module cop0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_ti;
  logic          w_tick;

  // A Count write restarts the prescaler and swallows this cycle's increment.
  assign w_tick = (r_pre == PRE_LAST) & ~i_count_we;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_count_we) begin
        r_count <= i_wdata;
        r_pre   <= '0;
      end else begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick) r_count <= r_count + 32'd1;
      end

      if (i_compare_we) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (w_tick && (r_count == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cop0_regfile.sv
// CP0 architectural state: MTC0/MFC0 access, exception/ERET commit, timer and interrupt request.
// Reads are combinational with same-cycle write bypass; updates take one edge; no backpressure.
module cop0_regfile
  import cop0_regs::*;
#(
  parameter int          N_HW_INT   = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VALUE = 32'h0001_8000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [2:0]          wsel,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  input  logic [2:0]          rsel,
  output logic [31:0]         rdata,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_bd,
  input  logic                exc_badvaddr_valid,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  input  logic [N_HW_INT-1:0] hw_int,
  output logic                int_pending,
  output logic [31:0]         epc,
  output logic                exl,
  output logic                timer_irq
);

  logic [31:0]         r_badvaddr;
  logic [31:0]         r_epc;
  logic [7:0]          r_im;
  logic                r_exl;
  logic                r_ie;
  logic                r_bd;
  logic [4:0]          r_exccode;
  logic [1:0]          r_ip_sw;
  logic [N_HW_INT-1:0] r_ip_hw;

  logic        w_wr_hit;
  logic        w_count_we;
  logic        w_compare_we;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_rd_cur;
  logic [31:0] w_wval;
  logic        w_bypass;

  // Exception and ERET commits flush any MTC0 retiring in the same cycle.
  assign w_wr_hit     = we & ~exc_valid & ~eret & (wsel == 3'd0);
  assign w_count_we   = w_wr_hit & (waddr == REG_COUNT);
  assign w_compare_we = w_wr_hit & (waddr == REG_COMPARE);

  cop0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_count_we   (w_count_we),
    .i_compare_we (w_compare_we),
    .i_wdata      (wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  always_comb begin
    w_ip                 = '0;
    w_ip[1:0]            = r_ip_sw;
    w_ip[N_HW_INT+1:2]   = r_ip_hw;
    w_ip[7]              = w_ip[7] | w_ti;
  end

  always_comb begin
    w_status                 = STATUS_BEV;
    w_status[ST_IM_LO +: 8]  = r_im;
    w_status[ST_EXL]         = r_exl;
    w_status[ST_IE]          = r_ie;
  end

  always_comb begin
    w_cause                  = '0;
    w_cause[CA_BD]           = r_bd;
    w_cause[CA_TI]           = w_ti;
    w_cause[CA_IP_LO +: 8]   = w_ip;
    w_cause[CA_EXC_LO +: 5]  = r_exccode;
  end

  always_comb begin
    w_rd_cur = '0;
    if (rsel == 3'd0) begin
      case (raddr)
        REG_BADVADDR: w_rd_cur = r_badvaddr;
        REG_COUNT:    w_rd_cur = w_count;
        REG_COMPARE:  w_rd_cur = w_compare;
        REG_STATUS:   w_rd_cur = w_status;
        REG_CAUSE:    w_rd_cur = w_cause;
        REG_EPC:      w_rd_cur = r_epc;
        REG_PRID:     w_rd_cur = PRID_VALUE;
        default:      w_rd_cur = '0;
      endcase
    end
  end

  // Value the written register will hold after this edge, as seen by MFC0.
  always_comb begin
    w_wval = '0;
    case (waddr)
      REG_COUNT,
      REG_COMPARE,
      REG_EPC:    w_wval = wdata;
      REG_STATUS: w_wval = (wdata & STATUS_WMASK) | STATUS_BEV;
      REG_CAUSE:  w_wval = (w_cause & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
      default:    w_wval = '0;
    endcase
  end

  assign w_bypass = w_wr_hit & (waddr == raddr) & (wsel == rsel) & reg_writable(waddr);
  assign rdata    = w_bypass ? w_wval : w_rd_cur;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_badvaddr <= '0;
      r_epc      <= '0;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
    end else begin
      r_ip_hw <= hw_int;
      if (exc_valid) begin
        r_exccode <= exc_code;
        // A nested exception keeps the original return point.
        if (!r_exl) begin
          r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          r_bd  <= exc_bd;
        end
        r_exl <= 1'b1;
        if (exc_badvaddr_valid) r_badvaddr <= exc_badvaddr;
      end else if (eret) begin
        r_exl <= 1'b0;
      end else if (w_wr_hit) begin
        case (waddr)
          REG_STATUS: begin
            r_im  <= wdata[ST_IM_LO +: 8];
            r_exl <= wdata[ST_EXL];
            r_ie  <= wdata[ST_IE];
          end
          REG_CAUSE: r_ip_sw <= wdata[CA_IP_LO +: 2];
          REG_EPC:   r_epc   <= wdata;
          default:   ;
        endcase
      end
    end
  end

  assign int_pending = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign epc         = r_epc;
  assign exl         = r_exl;
  assign timer_irq   = w_ti;

endmodule
